// File: rtl/stepper_phase_decoder.sv
// stepper_phase_decoder
//   Decodes 4-wire stepper coil phase patterns {b2,b1,a2,a1} back into a signed step
//   position and a signed step period (clocks between the last two same-direction steps).
//   Inputs pass through a 2-FF synchronizer and a debounce counter; each stable pattern
//   is accepted once and fed to a two-state (IDLE/TRACK) tracker.
//
// Parameters
//   STEPTYPE    0=WAVE, 1=FULL (phase-index advance 2), 2=HALF (advance 1)
//   DEBOUNCE    cycles a synchronized pattern must stay stable before acceptance (>=1)
//   PERIOD_MAX  period counter saturation; reaching it means "stopped"
//
// Ports
//   clk          system clock
//   rst          asynchronous reset, active-high
//   enable       decoder enable; when low the tracker idles and period is forced to 0
//   a1,a2,b1,b2  coil phase inputs, asynchronous to clk
//   clear_error  clears the sticky error flag (a simultaneous new error wins)
//   position     signed step count, wraps two's-complement
//   period       signed clocks between last two same-direction steps (+fwd, -rev, 0 stopped)
//   direction    1 = last step was forward
//   step_pulse   one-cycle strobe per decoded step
//   error        sticky illegal-transition flag
module stepper_phase_decoder #(
    parameter int unsigned STEPTYPE   = 1,
    parameter int unsigned DEBOUNCE   = 4,
    parameter int unsigned PERIOD_MAX = 50000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        a1,
    input  logic        a2,
    input  logic        b1,
    input  logic        b2,
    input  logic        clear_error,
    output logic [31:0] position,
    output logic [31:0] period,
    output logic        direction,
    output logic        step_pulse,
    output logic        error
);

    localparam int unsigned    DbW       = $clog2(DEBOUNCE + 2);
    localparam logic [DbW-1:0] DbAccept  = DbW'(DEBOUNCE);
    localparam logic [DbW-1:0] DbDone    = DbW'(DEBOUNCE + 1);
    localparam logic [2:0]     AdvFwd    = (STEPTYPE == 2) ? 3'd1 : 3'd2;
    localparam logic [2:0]     AdvRev    = 3'd0 - AdvFwd;
    localparam logic [31:0]    PeriodMax = 32'(PERIOD_MAX);

    typedef enum logic {StIdle, StTrack} state_e;

    // {valid, index}; 0000 and any pattern outside the table return invalid
    function automatic logic [3:0] phase_lookup(input logic [3:0] p);
        logic [3:0] r;
        case (p)
            4'b1000: r = {1'b1, 3'd0};
            4'b1100: r = {1'b1, 3'd1};
            4'b0100: r = {1'b1, 3'd2};
            4'b0110: r = {1'b1, 3'd3};
            4'b0010: r = {1'b1, 3'd4};
            4'b0011: r = {1'b1, 3'd5};
            4'b0001: r = {1'b1, 3'd6};
            4'b1001: r = {1'b1, 3'd7};
            default: r = 4'b0000;
        endcase
        return r;
    endfunction

    logic [3:0]     sync1_q, sync2_q, stab_q;
    logic [DbW-1:0] db_cnt_q, db_cnt_d;
    logic           accept;

    state_e         state_q, state_d;
    logic [2:0]     ref_q, ref_d;
    logic           have_prev_q, have_prev_d;
    logic [31:0]    position_q, position_d;
    logic [31:0]    period_q, period_d;
    logic [31:0]    pcnt_q, pcnt_d;
    logic           direction_q, direction_d;
    logic           step_pulse_q, step_pulse_d;
    logic           error_q, error_d;

    logic [3:0]     lu;
    logic           pat_valid, pat_idle;
    logic [2:0]     pat_idx, delta;
    logic           step_fwd, step_rev, err_set;
    logic [31:0]    elapsed;

    assign lu        = phase_lookup(stab_q);
    assign pat_valid = lu[3];
    assign pat_idx   = lu[2:0];
    assign pat_idle  = (stab_q == 4'b0000);
    assign delta     = pat_idx - ref_q;
    // Clocks since the previous step, counting the current edge
    assign elapsed   = pcnt_q + 32'd1;

    // Debounce: the count restarts on every change of the synchronized pattern and
    // parks one past the acceptance value so each stable pattern is accepted once.
    always_comb begin
        db_cnt_d = db_cnt_q;
        accept   = 1'b0;
        if (sync2_q != stab_q) begin
            db_cnt_d = DbW'(1);
        end else begin
            if (db_cnt_q != DbDone) begin
                db_cnt_d = db_cnt_q + DbW'(1);
            end
            accept = (db_cnt_q == DbAccept);
        end
    end

    // Tracker next-state
    always_comb begin
        state_d     = state_q;
        ref_d       = ref_q;
        have_prev_d = have_prev_q;
        step_fwd    = 1'b0;
        step_rev    = 1'b0;
        err_set     = 1'b0;
        if (enable && accept) begin
            case (state_q)
                StIdle: begin
                    if (pat_valid) begin
                        ref_d   = pat_idx;
                        state_d = StTrack;
                    end else if (!pat_idle) begin
                        err_set = 1'b1;
                    end
                end
                StTrack: begin
                    if (pat_valid) begin
                        ref_d = pat_idx;
                        if (delta == AdvFwd) begin
                            step_fwd    = 1'b1;
                            have_prev_d = 1'b1;
                        end else if (delta == AdvRev) begin
                            step_rev    = 1'b1;
                            have_prev_d = 1'b1;
                        end else if (delta != 3'd0) begin
                            // includes the ambiguous half-turn jump in FULL/WAVE
                            err_set = 1'b1;
                        end
                    end else begin
                        state_d     = StIdle;
                        have_prev_d = 1'b0;
                        err_set     = !pat_idle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
        if (!enable) begin
            state_d     = StIdle;
            have_prev_d = 1'b0;
        end
    end

    // Position / period / flags next-state
    always_comb begin
        position_d   = position_q;
        direction_d  = direction_q;
        step_pulse_d = step_fwd | step_rev;
        period_d     = period_q;
        pcnt_d       = (pcnt_q == PeriodMax) ? pcnt_q : pcnt_q + 32'd1;
        if (pcnt_d == PeriodMax) begin
            period_d = '0;
        end
        if (step_fwd || step_rev) begin
            position_d  = step_fwd ? position_q + 32'd1 : position_q - 32'd1;
            direction_d = step_fwd;
            pcnt_d      = '0;
            if (have_prev_q && (direction_q == step_fwd) && (pcnt_q < PeriodMax - 32'd1)) begin
                period_d = step_fwd ? elapsed : 32'd0 - elapsed;
            end else begin
                period_d = '0;
            end
        end
        if (!enable) begin
            period_d = '0;
            pcnt_d   = '0;
        end
        error_d = err_set | (error_q & ~clear_error);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            stab_q       <= '0;
            db_cnt_q     <= '0;
            state_q      <= StIdle;
            ref_q        <= '0;
            have_prev_q  <= 1'b0;
            position_q   <= '0;
            period_q     <= '0;
            pcnt_q       <= '0;
            direction_q  <= 1'b0;
            step_pulse_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            sync1_q      <= {b2, b1, a2, a1};
            sync2_q      <= sync1_q;
            stab_q       <= sync2_q;
            db_cnt_q     <= db_cnt_d;
            state_q      <= state_d;
            ref_q        <= ref_d;
            have_prev_q  <= have_prev_d;
            position_q   <= position_d;
            period_q     <= period_d;
            pcnt_q       <= pcnt_d;
            direction_q  <= direction_d;
            step_pulse_q <= step_pulse_d;
            error_q      <= error_d;
        end
    end

    assign position   = position_q;
    assign period     = period_q;
    assign direction  = direction_q;
    assign step_pulse = step_pulse_q;
    assign error      = error_q;

endmodule

// File: tb/tb_stepper_phase_decoder.sv
// Bench for stepper_phase_decoder: one HALF-step and one FULL-step instance (both
// DEBOUNCE=4, PERIOD_MAX=1000). Expected steps are queued when a pattern is driven and
// checked by a monitor when step_pulse appears.
module tb_stepper_phase_decoder;

    localparam int unsigned Deb  = 4;
    localparam int unsigned PMax = 1000;

    typedef struct {
        logic [31:0] pos;
        logic        dir;
        logic [31:0] per;
    } exp_t;

    logic        clk, rst;
    logic [3:0]  pat_h, pat_f;
    logic        en_h, en_f, clr_h, clr_f;
    logic [31:0] h_pos, h_per, f_pos, f_per;
    logic        h_dir, h_step, h_err, f_dir, f_step, f_err;

    int   total = 0;
    int   bad = 0;
    int   npulse_h = 0;
    int   npulse_f = 0;
    exp_t qh[$];
    exp_t qf[$];
    exp_t eh, ef;

    logic [3:0] tbl [8] = '{4'b1000, 4'b1100, 4'b0100, 4'b0110,
                            4'b0010, 4'b0011, 4'b0001, 4'b1001};

    stepper_phase_decoder #(.STEPTYPE(2), .DEBOUNCE(Deb), .PERIOD_MAX(PMax)) u_half (
        .clk(clk), .rst(rst), .enable(en_h),
        .a1(pat_h[0]), .a2(pat_h[1]), .b1(pat_h[2]), .b2(pat_h[3]),
        .clear_error(clr_h), .position(h_pos), .period(h_per),
        .direction(h_dir), .step_pulse(h_step), .error(h_err)
    );

    stepper_phase_decoder #(.STEPTYPE(1), .DEBOUNCE(Deb), .PERIOD_MAX(PMax)) u_full (
        .clk(clk), .rst(rst), .enable(en_f),
        .a1(pat_f[0]), .a2(pat_f[1]), .b1(pat_f[2]), .b2(pat_f[3]),
        .clear_error(clr_f), .position(f_pos), .period(f_per),
        .direction(f_dir), .step_pulse(f_step), .error(f_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void push_h(input int pos, input logic dir, input int per);
        exp_t e;
        e.pos = pos;
        e.dir = dir;
        e.per = per;
        qh.push_back(e);
    endfunction

    function automatic void push_f(input int pos, input logic dir, input int per);
        exp_t e;
        e.pos = pos;
        e.dir = dir;
        e.per = per;
        qf.push_back(e);
    endfunction

    // Scoreboard monitors
    always @(negedge clk) begin
        if (!rst && h_step) begin
            npulse_h++;
            total++;
            if (qh.size() == 0) begin
                bad++;
                $display("FAIL half_step_unexpected: got pos=%0d, required no step",
                         $signed(h_pos));
            end else begin
                eh = qh.pop_front();
                if ({h_pos, h_dir, h_per} !== {eh.pos, eh.dir, eh.per}) begin
                    bad++;
                    $display("FAIL half_step: got pos=%0d dir=%0b per=%0d, required pos=%0d dir=%0b per=%0d",
                             $signed(h_pos), h_dir, $signed(h_per),
                             $signed(eh.pos), eh.dir, $signed(eh.per));
                end
            end
        end
        if (!rst && f_step) begin
            npulse_f++;
            total++;
            if (qf.size() == 0) begin
                bad++;
                $display("FAIL full_step_unexpected: got pos=%0d, required no step",
                         $signed(f_pos));
            end else begin
                ef = qf.pop_front();
                if ({f_pos, f_dir, f_per} !== {ef.pos, ef.dir, ef.per}) begin
                    bad++;
                    $display("FAIL full_step: got pos=%0d dir=%0b per=%0d, required pos=%0d dir=%0b per=%0d",
                             $signed(f_pos), f_dir, $signed(f_per),
                             $signed(ef.pos), ef.dir, $signed(ef.per));
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        pat_h = 4'b0000; pat_f = 4'b0000;
        en_h = 1'b1; en_f = 1'b1; clr_h = 1'b0; clr_f = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({h_pos, h_per, h_dir, h_step, h_err} !== 67'd0) begin
            bad++;
            $display("FAIL reset_half: got pos=%0h per=%0h dir=%0b step=%0b err=%0b, required all 0",
                     h_pos, h_per, h_dir, h_step, h_err);
        end
        total++;
        if ({f_pos, f_per, f_dir, f_step, f_err} !== 67'd0) begin
            bad++;
            $display("FAIL reset_full: got pos=%0h per=%0h dir=%0b step=%0b err=%0b, required all 0",
                     f_pos, f_per, f_dir, f_step, f_err);
        end
        rst = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    task automatic test_async_reset();
        pat_h = tbl[0];
        repeat (20) @(negedge clk);
        for (int k = 1; k <= 5; k++) begin
            push_h(k, 1'b1, (k == 1) ? 0 : 20);
            pat_h = tbl[k];
            repeat (20) @(negedge clk);
        end
        total++;
        if (h_pos !== 32'd5 || h_per !== 32'd20) begin
            bad++;
            $display("FAIL async_pre: got pos=%0d per=%0d, required pos=5 per=20",
                     $signed(h_pos), $signed(h_per));
        end
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        total++;
        if ({h_pos, h_per, h_dir, h_step, h_err} !== 67'd0) begin
            bad++;
            $display("FAIL async_reset: got pos=%0d per=%0d dir=%0b before next clk, required all 0",
                     $signed(h_pos), $signed(h_per), h_dir);
        end
        pat_h = 4'b0000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        total++;
        if (qh.size() != 0) begin
            bad++;
            $display("FAIL async_queue: got %0d pending steps, required 0", qh.size());
        end
    endtask

    task automatic test_half_forward();
        int start;
        start = npulse_h;
        pat_h = tbl[0];
        repeat (100) @(negedge clk);
        for (int k = 1; k <= 8; k++) begin
            push_h(k, 1'b1, (k == 1) ? 0 : 100);
            pat_h = tbl[k % 8];
            if (k == 1) begin
                repeat (Deb + 2) @(posedge clk);
                #1;
                total++;
                if (h_step !== 1'b0 || h_pos !== 32'd0) begin
                    bad++;
                    $display("FAIL latency_early: got step=%0b pos=%0d one edge early, required 0/0",
                             h_step, $signed(h_pos));
                end
                @(posedge clk);
                #1;
                total++;
                if (h_step !== 1'b1 || h_pos !== 32'd1) begin
                    bad++;
                    $display("FAIL latency_exact: got step=%0b pos=%0d, required 1/1",
                             h_step, $signed(h_pos));
                end
                repeat (94) @(negedge clk);
            end else begin
                repeat (100) @(negedge clk);
            end
        end
        total++;
        if (h_pos !== 32'd8 || h_dir !== 1'b1 || npulse_h - start != 8) begin
            bad++;
            $display("FAIL half_fwd_end: got pos=%0d dir=%0b pulses=%0d, required 8/1/8",
                     $signed(h_pos), h_dir, npulse_h - start);
        end
    endtask

    task automatic test_period_timeout();
        push_h(9, 1'b1, 100);
        pat_h = tbl[1];
        repeat (200) @(negedge clk);
        push_h(10, 1'b1, 200);
        pat_h = tbl[2];
        repeat (Deb + 3) @(posedge clk);
        #1;
        total++;
        if (h_step !== 1'b1 || h_per !== 32'd200) begin
            bad++;
            $display("FAIL timeout_step: got step=%0b per=%0d, required 1/200", h_step, $signed(h_per));
        end
        repeat (PMax - 1) @(posedge clk);
        #1;
        total++;
        if (h_per !== 32'd200) begin
            bad++;
            $display("FAIL timeout_early: got per=%0d one cycle before timeout, required 200",
                     $signed(h_per));
        end
        @(posedge clk);
        #1;
        total++;
        if (h_per !== 32'd0) begin
            bad++;
            $display("FAIL timeout_zero: got per=%0d, required 0", $signed(h_per));
        end
        @(negedge clk);
    endtask

    task automatic test_enable();
        push_h(11, 1'b1, 0);
        pat_h = tbl[3];
        repeat (20) @(negedge clk);
        push_h(12, 1'b1, 20);
        pat_h = tbl[4];
        repeat (20) @(negedge clk);
        en_h = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (h_per !== 32'd0 || h_pos !== 32'd12 || h_dir !== 1'b1) begin
            bad++;
            $display("FAIL disable_hold: got per=%0d pos=%0d dir=%0b, required 0/12/1",
                     $signed(h_per), $signed(h_pos), h_dir);
        end
        pat_h = tbl[5];
        repeat (20) @(negedge clk);
        en_h = 1'b1;
        repeat (5) @(negedge clk);
        pat_h = tbl[6];
        repeat (20) @(negedge clk);
        total++;
        if (h_pos !== 32'd12 || h_err !== 1'b0) begin
            bad++;
            $display("FAIL reenable_first: got pos=%0d err=%0b, required 12/0",
                     $signed(h_pos), h_err);
        end
        push_h(13, 1'b1, 0);
        pat_h = tbl[7];
        repeat (20) @(negedge clk);
        total++;
        if (h_pos !== 32'd13 || qh.size() != 0) begin
            bad++;
            $display("FAIL reenable_step: got pos=%0d pending=%0d, required 13/0",
                     $signed(h_pos), qh.size());
        end
    endtask

    task automatic test_full_reverse();
        logic [3:0] fwd [5];
        fwd = '{4'b1001, 4'b1100, 4'b0110, 4'b0011, 4'b1001};
        pat_f = fwd[0];
        repeat (50) @(negedge clk);
        for (int k = 1; k <= 4; k++) begin
            push_f(k, 1'b1, (k == 1) ? 0 : 50);
            pat_f = fwd[k];
            repeat (50) @(negedge clk);
        end
        total++;
        if (f_pos !== 32'd4) begin
            bad++;
            $display("FAIL full_fwd: got pos=%0d, required 4", $signed(f_pos));
        end
        for (int k = 3; k >= 0; k--) begin
            push_f(k, 1'b0, (k == 3) ? 0 : -50);
            pat_f = fwd[k];
            repeat (50) @(negedge clk);
        end
        total++;
        if (f_pos !== 32'd0 || f_dir !== 1'b0 || qf.size() != 0) begin
            bad++;
            $display("FAIL full_rev: got pos=%0d dir=%0b pending=%0d, required 0/0/0",
                     $signed(f_pos), f_dir, qf.size());
        end
    endtask

    task automatic test_full_error();
        pat_f = 4'b0110;
        repeat (20) @(negedge clk);
        total++;
        if (f_err !== 1'b1 || f_pos !== 32'd0) begin
            bad++;
            $display("FAIL d4_error: got err=%0b pos=%0d, required 1/0", f_err, $signed(f_pos));
        end
        clr_f = 1'b1;
        @(negedge clk);
        clr_f = 1'b0;
        total++;
        if (f_err !== 1'b0) begin
            bad++;
            $display("FAIL clear_error: got err=%0b, required 0", f_err);
        end
        pat_f = 4'b1001;
        repeat (Deb + 2) @(negedge clk);
        clr_f = 1'b1;
        @(negedge clk);
        clr_f = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (f_err !== 1'b1 || f_pos !== 32'd0) begin
            bad++;
            $display("FAIL set_clear_same: got err=%0b pos=%0d, required 1/0", f_err, $signed(f_pos));
        end
        clr_f = 1'b1;
        @(negedge clk);
        clr_f = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_glitch();
        int start;
        push_f(1, 1'b1, 0);
        pat_f = 4'b1100;
        repeat (20) @(negedge clk);
        start = npulse_f;
        pat_f = 4'b0100;
        repeat (3) @(negedge clk);
        pat_f = 4'b1100;
        repeat (30) @(negedge clk);
        total++;
        if (f_pos !== 32'd1 || f_err !== 1'b0 || npulse_f != start || qf.size() != 0) begin
            bad++;
            $display("FAIL glitch: got pos=%0d err=%0b pulses=%0d pending=%0d, required 1/0/0/0",
                     $signed(f_pos), f_err, npulse_f - start, qf.size());
        end
    endtask

    initial begin
        test_reset();
        test_async_reset();
        test_half_forward();
        test_period_timeout();
        test_enable();
        test_full_reverse();
        test_full_error();
        test_glitch();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
